data_memory_responder: RTL
==========================

# data_memory_responder

Responder end of the CPU data-memory interface: the word-addressed RAM that services the CPU's load/store strobes (`selData`, `ldData`, `clrData`) over the shared tristate `data` bus. Loads are answered combinationally in the same cycle. Stores commit on the clock edge. A clear request starts a one-word-per-cycle zeroing sweep, and memory stays coherent while the sweep runs. It sits beside the instruction ROM on the CPU's external pins.

## Interface
- `ADDR_W`, 12, address width; matches CPU `dataAddr`.
- `DATA_W`, 16, word width; matches CPU `data`.
- `DEPTH`, 4096, implemented words; must satisfy `DEPTH` ≤ 2^`ADDR_W`, `DEPTH` ≥ 2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `res`  in  1  reset, synchronous and active-high.
- `enable`  in  1  global enable; when low, nothing is written and the bus is not driven.
- `dataAddr`  in  ADDR_W  word address from CPU.
- `data`  inout  DATA_W  shared bus; driven here only during a load.
- `selData`  in  1  access strobe (load or store).
- `ldData`  in  1  1 = load (responder drives), 0 = store (CPU drives).
- `clrData`  in  1  clear request; synchronous, level-sampled.
- `busy`  out  1  high while the clear sweep is active.
- `addrFault`  out  1  one-cycle registered pulse after any access with `dataAddr` ≥ `DEPTH`.

## Operation
- States: IDLE, CLEAR. Sweep pointer `clrPtr` is ADDR_W wide.
- Start or restart of a clear:
  - Any edge with `res` or `clrData` high sets `state` to CLEAR and `clrPtr` to 0.
  - This applies in every state, including mid-sweep, where the sweep restarts from 0.
- Sweep step: in CLEAR with `res` and `clrData` low, each edge writes `mem[clrPtr]` to 0 and increments `clrPtr`.
- Sweep end: the edge that writes `DEPTH-1` sets `state` to IDLE.
- Memory array contents are never reset directly; only the sweep zeroes them.
- Load condition: `enable & selData & ldData`.
  - When true, `data` is driven with the read value, combinationally from `dataAddr`.
  - Otherwise `data` is high-Z.
- Read value:
  - `dataAddr` ≥ `DEPTH`: 0.
  - In CLEAR with `dataAddr` ≥ `clrPtr` (not yet swept): 0.
  - Otherwise: `mem[dataAddr]`.
- Store condition: `enable & selData & ~ldData`. When true, `mem[dataAddr]` takes the value on `data` at the edge, subject to:
  - Dropped if `dataAddr` ≥ `DEPTH`.
  - Dropped if `res` or `clrData` is high in the same cycle (clear wins).
  - In CLEAR, accepted only if `dataAddr` < `clrPtr`; otherwise dropped, because the sweep would overwrite it.
- Store and sweep hitting the same address in one cycle: the sweep wins. The address is ≥ `clrPtr`, so the store is already dropped by the rule above.
- `addrFault`:
  - Set to 1 on the edge after an enabled access (load or store) with `dataAddr` ≥ `DEPTH`; cleared the following cycle.
  - Forced to 0 by `res`.
- `busy` = (`state` == CLEAR), registered.

## Timing
- Values after an edge with `res` high: `state` = CLEAR, `clrPtr` = 0, `busy` = 1, `addrFault` = 0, `data` high-Z.
- Load latency is 0 cycles (combinational), so the CPU can register the value on the same edge.
- Store latency is 1 edge. A load of the same address in the store cycle returns the old value; the new value is visible from the next cycle.
- Clear duration: `busy` stays high for exactly `DEPTH` edges after the last edge on which `res` or `clrData` was sampled high.
- `data` is never driven while `ldData` is 0, so there is no bus contention with CPU stores.

## Structure
- Shared package `data_mem_pkg` holds:
  - constants `DATA_ADDR_W` = 12 and `DATA_W` = 16;
  - state enum `dmem_state_t` {IDLE, CLEAR}.
- Sub-module `clear_sweeper`:
  - owns `state`, `clrPtr` and `busy`;
  - outputs the sweep write-enable, the sweep address, and the "address already swept" compare (`addr` < `clrPtr`).
- The top level holds the array, the read mux, the tristate driver, the store gating and `addrFault`.

## Test plan
- Reset sweep: pulse `res` for 1 cycle with `DEPTH` = 16 → `busy` is high for 16 edges, then low; reads of 0–15 return 0.
- Store then load: store 0xBEEF to address 5 → a load of 5 in the same cycle returns the old value; the next cycle returns 0xBEEF; `data` is Z whenever no load is active.
- Store during sweep: `DEPTH` = 16, `clrPtr` = 8.
  - Store 0x1234 to 3 → kept.
  - Store 0x5678 to 12 → dropped.
  - After `busy` falls: address 3 reads 0x1234, address 12 reads 0.
- Clear restart: assert `clrData` when `clrPtr` = 10 → `clrPtr` returns to 0; `busy` lasts 16 more edges; a store issued in the same cycle as `clrData` is lost.
- Out of range: `DEPTH` = 16, load 20 → bus reads 0 and `addrFault` pulses for one cycle; a store of 0xFFFF to 20 leaves addresses 4 and 20 unchanged.
- Enable low: `selData` = 1 and `ldData` = 1 with `enable` = 0 → `data` is Z; stores with `enable` = 0 do not write.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: bus widths and the
// clear-sweep state encoding.
package data_mem_pkg;

   localparam int DATA_ADDR_W = 12;
   localparam int DATA_W      = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } dmem_state_t;

endpackage

// File: rtl/data_memory_responder_sweeper.sv
// Clear sweeper: walks a zero-write pointer across the array one word per cycle,
// restarting from word 0 whenever reset or a clear request is sampled.
module clear_sweeper #(
   parameter int ADDR_W = data_mem_pkg::DATA_ADDR_W,
   parameter int DEPTH  = 4096,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              res,
   input  logic              clrData,
   input  logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              sweep_we,
   output logic [IDX_W-1:0]  sweep_addr,
   output logic              addr_swept
);
   import data_mem_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   dmem_state_t       r_state;
   dmem_state_t       w_state_next;
   logic [ADDR_W-1:0] r_clr_ptr;
   logic [ADDR_W-1:0] w_clr_ptr_next;
   logic              w_restart;

   assign w_restart = res | clrData;

   always_ff @(posedge clk) begin
      if (res) begin
         r_state   <= CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_ptr <= w_clr_ptr_next;
      end
   end

   // A restart outranks the sweep step, so a clear landing mid-sweep begins again at 0.
   always_comb begin
      w_state_next   = r_state;
      w_clr_ptr_next = r_clr_ptr;
      sweep_we       = 1'b0;
      if (w_restart) begin
         w_state_next   = CLEAR;
         w_clr_ptr_next = '0;
      end else if (r_state == CLEAR) begin
         sweep_we       = 1'b1;
         w_clr_ptr_next = r_clr_ptr + 1'b1;
         if (r_clr_ptr == LAST_ADDR) begin
            w_state_next = IDLE;
         end
      end
   end

   assign busy       = (r_state == CLEAR);
   assign sweep_addr = r_clr_ptr[IDX_W-1:0];
   assign addr_swept = (addr < r_clr_ptr);

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM answering CPU load/store strobes on a shared tristate
// bus; loads are combinational, stores commit on the edge, clears sweep to zero.
module data_memory_responder #(
   parameter int ADDR_W = data_mem_pkg::DATA_ADDR_W,
   parameter int DATA_W = data_mem_pkg::DATA_W,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              res,
   input  logic              enable,
   input  logic [ADDR_W-1:0] dataAddr,
   inout  wire  [DATA_W-1:0] data,
   input  logic              selData,
   input  logic              ldData,
   input  logic              clrData,
   output logic              busy,
   output logic              addrFault
);
   localparam int              IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_addr_fault;

   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic              w_busy;
   logic              w_sweep_we;
   logic [IDX_W-1:0]  w_sweep_idx;
   logic              w_addr_swept;
   logic              w_load;
   logic              w_store;
   logic [DATA_W-1:0] w_read_data;

   clear_sweeper #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_sweeper (
      .clk        (clk),
      .res        (res),
      .clrData    (clrData),
      .addr       (dataAddr),
      .busy       (w_busy),
      .sweep_we   (w_sweep_we),
      .sweep_addr (w_sweep_idx),
      .addr_swept (w_addr_swept)
   );

   assign w_in_range = ({1'b0, dataAddr} < DEPTH_EXT);
   assign w_idx      = dataAddr[IDX_W-1:0];

   // Words the sweep has not reached yet read as zero even though the array still holds old data.
   always_comb begin
      w_read_data = '0;
      if (w_in_range && (!w_busy || w_addr_swept)) begin
         w_read_data = r_mem[w_idx];
      end
   end

   assign w_load = enable & selData & ldData;
   assign data   = w_load ? w_read_data : {DATA_W{1'bz}};

   // Stores into the unswept region are dropped since the sweep would zero them anyway.
   assign w_store = enable & selData & ~ldData & w_in_range & ~res & ~clrData
                    & (~w_busy | w_addr_swept);

   always_ff @(posedge clk) begin
      if (w_sweep_we) begin
         r_mem[w_sweep_idx] <= '0;
      end
      if (w_store) begin
         r_mem[w_idx] <= data;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_addr_fault <= 1'b0;
      end else begin
         r_addr_fault <= enable & selData & ~w_in_range;
      end
   end

   assign busy      = w_busy;
   assign addrFault = r_addr_fault;

endmodule
